// File: rtl/vga_pattern_pkg.sv
// Shared encodings and colour constants for the VGA test-pattern generator.
package vga_pattern_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_BOX   = 2'd3
    } pat_e;

    localparam int PIPE_LAT = 2;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;
    localparam logic [23:0] COL_BOX_FG  = 24'hFFFFFF;
    localparam logic [23:0] COL_BOX_BG  = 24'h000080;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            3'd7:    c = COL_BLACK;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_bounce.sv
// Bouncing-box position/direction state; advances one step per end-of-frame tick.
module vga_bounce_ctrl #(
    parameter int H_PIXELS = 1920,
    parameter int V_PIXELS = 1080,
    parameter int BOX_SIZE = 64,
    parameter int BOX_STEP = 4
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    input  logic        eof,
    output logic [31:0] box_x,
    output logic [31:0] box_y
);

    localparam logic [31:0] H_L    = 32'(H_PIXELS);
    localparam logic [31:0] V_L    = 32'(V_PIXELS);
    localparam logic [31:0] SIZE_L = 32'(BOX_SIZE);
    localparam logic [31:0] STEP_L = 32'(BOX_STEP);

    logic [31:0] box_x_r;
    logic [31:0] box_y_r;
    logic        dx_neg_r;
    logic        dy_neg_r;
    logic [32:0] x_next_s;
    logic [32:0] y_next_s;

    // Returns {direction_negative, position} for one axis after a step.
    function automatic logic [32:0] axis_next(input logic [31:0] pos,
                                              input logic        neg,
                                              input logic [31:0] limit);
        logic [32:0] r;
        if (!neg && ((pos + SIZE_L + STEP_L) > limit)) begin
            r = {1'b1, limit - SIZE_L};
        end else if (neg && (pos < STEP_L)) begin
            r = {1'b0, 32'd0};
        end else if (neg) begin
            r = {1'b1, pos - STEP_L};
        end else begin
            r = {1'b0, pos + STEP_L};
        end
        return r;
    endfunction

    // Candidate next position for both axes.
    always_comb begin
        x_next_s = axis_next(box_x_r, dx_neg_r, H_L);
        y_next_s = axis_next(box_y_r, dy_neg_r, V_L);
    end

    // Position and direction registers, updated only on end of frame.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            box_x_r  <= 32'd0;
            box_y_r  <= 32'd0;
            dx_neg_r <= 1'b0;
            dy_neg_r <= 1'b0;
        end else if (eof) begin
            box_x_r  <= x_next_s[31:0];
            dx_neg_r <= x_next_s[32];
            box_y_r  <= y_next_s[31:0];
            dy_neg_r <= y_next_s[32];
        end else begin
            box_x_r  <= box_x_r;
            box_y_r  <= box_y_r;
            dx_neg_r <= dx_neg_r;
            dy_neg_r <= dy_neg_r;
        end
    end

    assign box_x = box_x_r;
    assign box_y = box_y_r;

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage VGA test-pattern source (bars, checker, gradient, bouncing box).
// Define VGA_BORDER_EN to overlay a 1-pixel white frame border.
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int   H_PIXELS   = 1920,
    parameter int   V_PIXELS   = 1080,
    parameter logic H_POL      = 1'b0,
    parameter logic V_POL      = 1'b1,
    parameter int   BOX_SIZE   = 64,
    parameter int   BOX_STEP   = 4,
    parameter int   CHECK_LOG2 = 5
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    input  logic        disp_ena_in,
    input  logic [31:0] column,
    input  logic [31:0] row,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic [1:0]  pattern_sel,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        disp_ena_out
);

    localparam logic [31:0] H_L    = 32'(H_PIXELS);
    localparam logic [31:0] V_L    = 32'(V_PIXELS);
    localparam logic [31:0] SIZE_L = 32'(BOX_SIZE);
    localparam logic [31:0] BAR_W  = 32'(H_PIXELS / 8);

    pat_e        active_pat_r;
    logic [7:0]  frame_cnt_r;
    logic        eof_s;
    logic [31:0] box_x_s;
    logic [31:0] box_y_s;
    logic [2:0]  bar_idx_s;
    logic        in_box_s;
    logic [23:0] pat_rgb_s;
    logic [23:0] rgb_fin_s;

    logic [23:0] rgb_s1_r;
    logic        de_s1_r;
    logic        hs_s1_r;
    logic        vs_s1_r;
    logic [23:0] rgb_s2_r;
    logic        de_s2_r;
    logic        hs_s2_r;
    logic        vs_s2_r;

    assign eof_s = disp_ena_in && (column == (H_L - 32'd1)) && (row == (V_L - 32'd1));

    vga_bounce_ctrl #(
        .H_PIXELS (H_PIXELS),
        .V_PIXELS (V_PIXELS),
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) u_bounce (
        .pixel_clk (pixel_clk),
        .reset_n   (reset_n),
        .eof       (eof_s),
        .box_x     (box_x_s),
        .box_y     (box_y_s)
    );

    // Frame-boundary state: pattern latch and frame counter.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            active_pat_r <= PAT_BARS;
            frame_cnt_r  <= 8'd0;
        end else if (eof_s) begin
            active_pat_r <= pat_e'(pattern_sel);
            frame_cnt_r  <= frame_cnt_r + 8'd1;
        end else begin
            active_pat_r <= active_pat_r;
            frame_cnt_r  <= frame_cnt_r;
        end
    end

    // Bar index by threshold compare; anything past bar 7 stays black (bar 7).
    always_comb begin
        bar_idx_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            bar_idx_s = (column >= (BAR_W * 32'(k))) ? 3'(k) : bar_idx_s;
        end
    end

    assign in_box_s = (column >= box_x_s) && (column < (box_x_s + SIZE_L)) &&
                      (row >= box_y_s)    && (row < (box_y_s + SIZE_L));

    // Per-pattern colour for the current pixel.
    always_comb begin
        pat_rgb_s = COL_BLACK;
        case (active_pat_r)
            PAT_BARS:  pat_rgb_s = bar_colour(bar_idx_s);
            PAT_CHECK: pat_rgb_s = (column[CHECK_LOG2] ^ row[CHECK_LOG2]) ? COL_WHITE : COL_BLACK;
            PAT_GRAD:  pat_rgb_s = {column[7:0], row[7:0], frame_cnt_r};
            PAT_BOX:   pat_rgb_s = in_box_s ? COL_BOX_FG : COL_BOX_BG;
            default:   pat_rgb_s = COL_BLACK;
        endcase
    end

`ifdef VGA_BORDER_EN
    logic border_s;
    logic border_s1_r;

    assign border_s = (column == 32'd0) || (column == (H_L - 32'd1)) ||
                      (row == 32'd0)    || (row == (V_L - 32'd1));

    // Border flag travels alongside stage 1.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            border_s1_r <= 1'b0;
        end else begin
            border_s1_r <= border_s;
        end
    end
`endif

    // Stage 1: pattern colour plus delayed sync/enable.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_s1_r <= 24'h000000;
            de_s1_r  <= 1'b0;
            hs_s1_r  <= ~H_POL;
            vs_s1_r  <= ~V_POL;
        end else begin
            rgb_s1_r <= pat_rgb_s;
            de_s1_r  <= disp_ena_in;
            hs_s1_r  <= h_sync_in;
            vs_s1_r  <= v_sync_in;
        end
    end

    // Blanking has priority over the border, which has priority over the pattern.
    always_comb begin
        rgb_fin_s = 24'h000000;
        if (!de_s1_r) begin
            rgb_fin_s = 24'h000000;
        end
`ifdef VGA_BORDER_EN
        else if (border_s1_r) begin
            rgb_fin_s = COL_WHITE;
        end
`endif
        else begin
            rgb_fin_s = rgb_s1_r;
        end
    end

    // Stage 2: final registered outputs.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_s2_r <= 24'h000000;
            de_s2_r  <= 1'b0;
            hs_s2_r  <= ~H_POL;
            vs_s2_r  <= ~V_POL;
        end else begin
            rgb_s2_r <= rgb_fin_s;
            de_s2_r  <= de_s1_r;
            hs_s2_r  <= hs_s1_r;
            vs_s2_r  <= vs_s1_r;
        end
    end

    assign red          = rgb_s2_r[23:16];
    assign green        = rgb_s2_r[15:8];
    assign blue         = rgb_s2_r[7:0];
    assign disp_ena_out = de_s2_r;
    assign h_sync_out   = hs_s2_r;
    assign v_sync_out   = vs_s2_r;

endmodule
